// File: rtl/line_engine_pkg.sv
// Shared types and constants for the Bresenham line engine.
package line_engine_pkg;

    localparam logic [11:0] FB_BASE_DEFAULT = 12'h010;
    localparam int unsigned SCREEN_W        = 800;
    localparam int unsigned SCREEN_H        = 600;

    localparam logic [15:0] MASK_NONE = 16'hFFFF;
    localparam logic [15:0] LANE0_EN  = 16'hF000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_BEAT0,
        S_BEAT1
    } state_e;

    typedef enum logic {
        BEAT_LO = 1'b0,
        BEAT_HI = 1'b1
    } beat_e;

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic on_screen(input logic [9:0] x, input logic [9:0] y);
        return (x < 10'(SCREEN_W)) && (y < 10'(SCREEN_H));
    endfunction

endpackage

// File: rtl/line_engine_addr.sv
// Pixel to DDR burst mapping: address, byte-enable mask and replicated colour.
module line_engine_addr
    import line_engine_pkg::*;
#(
    parameter logic [11:0] FB_BASE = FB_BASE_DEFAULT
) (
    input  logic [9:0]   x,
    input  logic [9:0]   y,
    input  logic [31:0]  color,
    input  beat_e        beat,
    output logic [30:0]  addr,
    output logic [15:0]  mask,
    output logic [127:0] data
);

    assign addr = {FB_BASE, y, x[9:3], 2'b00};
    assign data = {4{color}};

    // x[2] picks the half of the 8-pixel burst; x[1:0] picks the lane inside it.
    always_comb begin
        mask = MASK_NONE;
        if (beat_e'(x[2]) == beat) begin
            mask = ~(LANE0_EN >> {x[1:0], 2'b00});
        end
    end

endmodule

// File: rtl/line_engine.sv
// Bresenham line rasteriser issuing one two-beat masked DDR write per pixel.
// Define LE_CLIP_EN to skip pixels outside the 800x600 screen.
module line_engine
    import line_engine_pkg::*;
#(
    parameter logic [11:0] FB_BASE = FB_BASE_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    output logic         LE_ready,
    input  logic [31:0]  LE_color,
    input  logic [9:0]   LE_point,
    input  logic         LE_color_valid,
    input  logic         LE_x0_valid,
    input  logic         LE_y0_valid,
    input  logic         LE_x1_valid,
    input  logic         LE_y1_valid,
    input  logic         LE_trigger,
    input  logic         af_full,
    input  logic         wdf_full,
    output logic [30:0]  af_addr_din,
    output logic         af_wr_en,
    output logic [127:0] wdf_din,
    output logic [15:0]  wdf_mask_din,
    output logic         wdf_wr_en
);

    state_e             state_q, state_d;
    logic [31:0]        color_q, color_d;
    logic [9:0]         x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [9:0]         cx_q, cx_d, cy_q, cy_d, xend_q, xend_d;
    logic [9:0]         dx_q, dx_d, dy_q, dy_d;
    logic signed [11:0] err_q, err_d;
    logic               steep_q, steep_d, ystep_pos_q, ystep_pos_d;

    logic               steep_s;
    logic [9:0]         ax0, ay0, ax1, ay1, sx0, sy0, sx1, sy1, dx_s;
    logic signed [11:0] err_sub, step_err;
    logic [9:0]         step_y, px, py;
    logic               y_moves, clipped, advance;
    logic [15:0]        pix_mask;

    // Fold the line into the shallow, left-to-right octant used by the stepper.
    always_comb begin
        steep_s = abs_diff(y1_q, y0_q) > abs_diff(x1_q, x0_q);
        ax0 = steep_s ? y0_q : x0_q;
        ay0 = steep_s ? x0_q : y0_q;
        ax1 = steep_s ? y1_q : x1_q;
        ay1 = steep_s ? x1_q : y1_q;
        if (ax0 > ax1) begin
            sx0 = ax1; sy0 = ay1; sx1 = ax0; sy1 = ay0;
        end else begin
            sx0 = ax0; sy0 = ay0; sx1 = ax1; sy1 = ay1;
        end
        dx_s = sx1 - sx0;
    end

    assign err_sub  = err_q - $signed({2'b00, dy_q});
    assign y_moves  = err_sub[11];
    assign step_err = y_moves ? (err_sub + $signed({2'b00, dx_q})) : err_sub;
    assign step_y   = !y_moves ? cy_q : (ystep_pos_q ? cy_q + 10'd1 : cy_q - 10'd1);

    assign px = steep_q ? cy_q : cx_q;
    assign py = steep_q ? cx_q : cy_q;

`ifdef LE_CLIP_EN
    assign clipped = !on_screen(px, py);
`else
    assign clipped = 1'b0;
`endif

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        color_d     = color_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        xend_d      = xend_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        err_d       = err_q;
        steep_d     = steep_q;
        ystep_pos_d = ystep_pos_q;
        af_wr_en    = 1'b0;
        wdf_wr_en   = 1'b0;
        advance     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (LE_color_valid) color_d = LE_color;
                if (LE_x0_valid)    x0_d    = LE_point;
                if (LE_y0_valid)    y0_d    = LE_point;
                if (LE_x1_valid)    x1_d    = LE_point;
                if (LE_y1_valid)    y1_d    = LE_point;
                if (LE_trigger)     state_d = S_SETUP;
            end
            S_SETUP: begin
                cx_d        = sx0;
                cy_d        = sy0;
                xend_d      = sx1;
                dx_d        = dx_s;
                dy_d        = abs_diff(sy1, sy0);
                err_d       = $signed({3'b000, dx_s[9:1]});
                steep_d     = steep_s;
                ystep_pos_d = sy1 > sy0;
                state_d     = S_BEAT0;
            end
            S_BEAT0: begin
                if (clipped) begin
                    advance = 1'b1;
                end else if (!af_full && !wdf_full) begin
                    af_wr_en  = 1'b1;
                    wdf_wr_en = 1'b1;
                    state_d   = S_BEAT1;
                end
            end
            S_BEAT1: begin
                if (!wdf_full) begin
                    wdf_wr_en = 1'b1;
                    advance   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (cx_q == xend_q) begin
                state_d = S_IDLE;
            end else begin
                cx_d    = cx_q + 10'd1;
                cy_d    = step_y;
                err_d   = step_err;
                state_d = S_BEAT0;
            end
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            color_q     <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            xend_q      <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            err_q       <= '0;
            steep_q     <= 1'b0;
            ystep_pos_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            color_q     <= color_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            xend_q      <= xend_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            err_q       <= err_d;
            steep_q     <= steep_d;
            ystep_pos_q <= ystep_pos_d;
        end
    end

    line_engine_addr #(.FB_BASE(FB_BASE)) u_addr (
        .x     (px),
        .y     (py),
        .color (color_q),
        .beat  ((state_q == S_BEAT1) ? BEAT_HI : BEAT_LO),
        .addr  (af_addr_din),
        .mask  (pix_mask),
        .data  (wdf_din)
    );

    assign wdf_mask_din = ((state_q == S_BEAT0) || (state_q == S_BEAT1)) ? pix_mask : MASK_NONE;
    assign LE_ready     = (state_q == S_IDLE);

endmodule

// File: tb/tb_line_engine.sv
// Scoreboard bench for line_engine: integer Bresenham model feeds expected beats,
// a negedge monitor pops and compares every FIFO push.
module tb_line_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         LE_ready;
    logic [31:0]  LE_color;
    logic [9:0]   LE_point;
    logic         LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid;
    logic         LE_trigger;
    logic         af_full, wdf_full;
    logic [30:0]  af_addr_din;
    logic         af_wr_en;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;
    logic         wdf_wr_en;

    line_engine dut (
        .clk            (clk),
        .rst            (rst),
        .LE_ready       (LE_ready),
        .LE_color       (LE_color),
        .LE_point       (LE_point),
        .LE_color_valid (LE_color_valid),
        .LE_x0_valid    (LE_x0_valid),
        .LE_y0_valid    (LE_y0_valid),
        .LE_x1_valid    (LE_x1_valid),
        .LE_y1_valid    (LE_y1_valid),
        .LE_trigger     (LE_trigger),
        .af_full        (af_full),
        .wdf_full       (wdf_full),
        .af_addr_din    (af_addr_din),
        .af_wr_en       (af_wr_en),
        .wdf_din        (wdf_din),
        .wdf_mask_din   (wdf_mask_din),
        .wdf_wr_en      (wdf_wr_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]  mask;
        logic [127:0] data;
    } beat_t;

    localparam int BUDGET = 8000;

    logic [30:0] exp_addr[$];
    beat_t       exp_beat[$];
    logic [19:0] obs_pix[$];
    int          checks   = 0;
    int          failures = 0;
    bit          mon_en   = 1'b0;
    bit          stall_en = 1'b0;
    logic [30:0] cur_addr = '0;
    logic        mon_beat;
    int          mon_lane;
    beat_t       mon_exp;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // One pixel = address + two data beats; the lane's byte enables are cleared.
    task automatic push_pixel(input int px, input int py, input logic [31:0] col);
        logic [15:0] m;
        beat_t       b0, b1;
        int          lane;
        lane = px % 4;
        m    = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            if (i == lane) m[15-4*i -: 4] = 4'h0;
        end
        exp_addr.push_back(31'((32'h010 << 19) + (py << 9) + ((px / 8) << 2)));
        b0.data = {4{col}};
        b1.data = {4{col}};
        if ((px / 4) % 2 == 0) begin
            b0.mask = m;
            b1.mask = 16'hFFFF;
        end else begin
            b0.mask = 16'hFFFF;
            b1.mask = m;
        end
        exp_beat.push_back(b0);
        exp_beat.push_back(b1);
    endtask

    task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1,
                              input logic [31:0] col);
        int x0, y0, x1, y1, t, dx, dy, err, ystep, y;
        bit steep;
        x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1;
        steep = iabs(y1 - y0) > iabs(x1 - x0);
        if (steep) begin
            t = x0; x0 = y0; y0 = t;
            t = x1; x1 = y1; y1 = t;
        end
        if (x0 > x1) begin
            t = x0; x0 = x1; x1 = t;
            t = y0; y0 = y1; y1 = t;
        end
        dx    = x1 - x0;
        dy    = iabs(y1 - y0);
        err   = dx / 2;
        ystep = (y0 < y1) ? 1 : -1;
        y     = y0;
        for (int x = x0; x <= x1; x++) begin
            if (steep) push_pixel(y, x, col);
            else       push_pixel(x, y, col);
            err -= dy;
            if (err < 0) begin
                y   += ystep;
                err += dx;
            end
        end
    endtask

    // Random FIFO back-pressure, changed just after each rising edge.
    initial begin
        af_full  = 1'b0;
        wdf_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            af_full  = stall_en && ($urandom_range(0, 2) == 0);
            wdf_full = stall_en && ($urandom_range(0, 2) == 0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_af_wr_en", af_wr_en, 1'b0);
            check("rst_wdf_wr_en", wdf_wr_en, 1'b0);
        end else if (mon_en) begin
            if (af_wr_en) begin
                check("af_push_while_full", af_full, 1'b0);
                if (exp_addr.size() == 0) fail_now("af_unexpected_push");
                else check("af_addr", af_addr_din, exp_addr.pop_front());
                cur_addr = af_addr_din;
                mon_beat = 1'b0;
            end else begin
                mon_beat = 1'b1;
            end
            if (wdf_wr_en) begin
                check("wdf_push_while_full", wdf_full, 1'b0);
                if (exp_beat.size() == 0) begin
                    fail_now("wdf_unexpected_push");
                end else begin
                    mon_exp = exp_beat.pop_front();
                    check("wdf_mask", wdf_mask_din, mon_exp.mask);
                    check("wdf_data", wdf_din, mon_exp.data);
                end
                if (wdf_mask_din != 16'hFFFF) begin
                    mon_lane = 0;
                    for (int i = 0; i < 4; i++) begin
                        if (wdf_mask_din[15-4*i -: 4] == 4'h0) mon_lane = i;
                    end
                    obs_pix.push_back({cur_addr[18:9], cur_addr[8:2], mon_beat, 2'(mon_lane)});
                end
            end
        end
    end

    task automatic strobe(input int which, input logic [9:0] v);
        LE_point = v;
        case (which)
            0:       LE_x0_valid = 1'b1;
            1:       LE_y0_valid = 1'b1;
            2:       LE_x1_valid = 1'b1;
            default: LE_y1_valid = 1'b1;
        endcase
        @(posedge clk);
        #1;
        {LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid} = '0;
    endtask

    // mode 0: trigger only, 1: colour then trigger, 2: colour + endpoints then trigger
    task automatic load_and_trigger(input int x0, input int y0, input int x1, input int y1,
                                    input logic [31:0] col, input int mode, input bit bypass);
        if (mode >= 1) begin
            LE_color       = col;
            LE_color_valid = 1'b1;
            @(posedge clk);
            #1;
            LE_color_valid = 1'b0;
        end
        if (mode == 2) begin
            strobe(0, 10'(x0));
            strobe(1, 10'(y0));
            strobe(2, 10'(x1));
            if (!bypass) strobe(3, 10'(y1));
        end
        check("ready_before_trigger", LE_ready, 1'b1);
        LE_trigger = 1'b1;
        if (mode == 2 && bypass) begin
            LE_point    = 10'(y1);
            LE_y1_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        LE_trigger  = 1'b0;
        LE_y1_valid = 1'b0;
    endtask

    task automatic draw(input int x0, input int y0, input int x1, input int y1,
                        input logic [31:0] col, input int mode, input bit bypass, input bit garbage);
        int n;
        bit ends_ok;
        logic [19:0] p0, p1;
        obs_pix.delete();
        model_line(x0, y0, x1, y1, col);
        load_and_trigger(x0, y0, x1, y1, col, mode, bypass);
        check("ready_drop", LE_ready, 1'b0);
        if (garbage) begin
            LE_point   = 10'($urandom);
            LE_color   = $urandom;
            {LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger} = '1;
            @(posedge clk);
            #1;
            {LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger} = '0;
        end
        n = 0;
        while (!LE_ready && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!LE_ready) fail_now("draw_timeout");
        check("pix_count", 32'(obs_pix.size()),
              32'((iabs(x1 - x0) > iabs(y1 - y0) ? iabs(x1 - x0) : iabs(y1 - y0)) + 1));
        if (obs_pix.size() > 0) begin
            p0 = {10'(y0), 10'(x0)};
            p1 = {10'(y1), 10'(x1)};
            ends_ok = (obs_pix[0] == p0 && obs_pix[$] == p1) || (obs_pix[0] == p1 && obs_pix[$] == p0);
            check("endpoints", ends_ok, 1'b1);
        end
        check("sb_addr_left", 32'(exp_addr.size()), 32'd0);
        check("sb_beat_left", 32'(exp_beat.size()), 32'd0);
    endtask

    initial begin
        int rx0, ry0, rx1, ry1;
        rst        = 1'b0;
        LE_color   = '0;
        LE_point   = '0;
        {LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger} = '0;
        #1;
        check("reset_ready", LE_ready, 1'b1);
        check("reset_af_wr_en", af_wr_en, 1'b0);
        check("reset_wdf_wr_en", wdf_wr_en, 1'b0);
        check("reset_mask", wdf_mask_din, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;

        draw(0, 0, 799, 599, 32'h007F0000, 2, 1'b1, 1'b0);
        draw(10, 5, 17, 5, 32'h00123456, 2, 1'b0, 1'b0);
        draw(750, 550, 0, 0, 32'h0000FF00, 2, 1'b0, 1'b0);
        draw(0, 0, 300, 550, 32'h000000FF, 2, 1'b1, 1'b0);
        draw(123, 456, 123, 456, 32'h00ABCDEF, 2, 1'b0, 1'b0);
        draw(5, 5, 40, 20, 32'h00111111, 2, 1'b0, 1'b1);
        draw(5, 5, 40, 20, 32'h00222222, 1, 1'b0, 1'b0);

        stall_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rx0 = $urandom_range(0, 799);
            ry0 = $urandom_range(0, 599);
            rx1 = $urandom_range(0, 799);
            ry1 = $urandom_range(0, 599);
            draw(rx0, ry0, rx1, ry1, {8'h00, 24'($urandom)}, 2, 1'($urandom), 1'b0);
        end
        stall_en = 1'b0;

        model_line(0, 0, 799, 599, 32'h00C0FFEE);
        load_and_trigger(0, 0, 799, 599, 32'h00C0FFEE, 2, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        check("abort_af_wr_en", af_wr_en, 1'b0);
        check("abort_wdf_wr_en", wdf_wr_en, 1'b0);
        check("abort_mask", wdf_mask_din, 16'hFFFF);
        check("abort_ready", LE_ready, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_addr.delete();
        exp_beat.delete();
        mon_en = 1'b1;
        draw(0, 0, 0, 0, 32'h00000000, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
